// File: rtl/params_pkg.sv
// Shared types and constants for the execute-stage arithmetic units.
package params_pkg;

   localparam int unsigned MULDIV_XLEN_DEFAULT = 32;

   // Values match the funct3 field of the M-extension encodings.
   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: bit-serial over XLEN cycles, then sign fix-up.
// Optional MULDIV_FAST_PATH_EN: divide-by-zero and signed-overflow divides finish in one cycle.
module muldiv_unit
   import params_pkg::*;
#(
   parameter int unsigned XLEN = MULDIV_XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned W2 = 2 * XLEN;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + XLEN'(1)) : v;
   endfunction

   muldiv_state_e   state_q;
   muldiv_op_e      op_q;
   logic [CW-1:0]   cnt_q;
   logic [W2-1:0]   acc_q;
   logic [XLEN-1:0] bmag_q;
   logic [XLEN-1:0] result_q;
   logic            sa_q, sb_q, dz_q, busy_q, valid_q;

   logic            sa_in, sb_in;
   logic [XLEN:0]   mul_sum, div_trial, div_diff;
   logic [W2-1:0]   acc_step, prod;
   logic [XLEN-1:0] quot, rem, fix_result;

   // Operand signedness: divides are signed when funct3[0]=0; MULHU is fully unsigned,
   // MULHSU treats only rs1 as signed.
   always_comb begin
      sa_in = (funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11)) & a_i[XLEN-1];
      sb_in = (funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1]) & b_i[XLEN-1];
   end

   // acc_q holds {high product, low multiplier} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
      div_trial = acc_q[W2-1:XLEN-1];
      div_diff  = div_trial - {1'b0, bmag_q};
      acc_step  = {mul_sum, acc_q[XLEN-1:1]};
      if (op_q[2]) begin
         if (div_diff[XLEN]) begin
            acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         end else begin
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         end
      end
   end

   always_comb begin
      prod = (sa_q ^ sb_q) ? (~acc_q + W2'(1)) : acc_q;
      quot = dz_q ? '1 : cond_neg(acc_q[XLEN-1:0], sa_q ^ sb_q);
      rem  = cond_neg(acc_q[W2-1:XLEN], sa_q);
      fix_result = '0;
      unique case (op_q)
         OpMul:                      fix_result = prod[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu:  fix_result = prod[W2-1:XLEN];
         OpDiv, OpDivu:              fix_result = quot;
         OpRem, OpRemu:              fix_result = rem;
         default:                    fix_result = '0;
      endcase
   end

`ifdef MULDIV_FAST_PATH_EN
   logic            fast_dz, fast_ovf, fast_in;
   logic [XLEN-1:0] fast_result;

   always_comb begin
      fast_dz     = (b_i == '0);
      fast_ovf    = ~funct3_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
      fast_in     = funct3_i[2] && (fast_dz || fast_ovf);
      fast_result = '0;
      if (fast_dz) begin
         fast_result = funct3_i[1] ? a_i : '1;
      end else if (fast_ovf) begin
         fast_result = funct3_i[1] ? '0 : a_i;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= OpMul;
         cnt_q    <= '0;
         acc_q    <= '0;
         bmag_q   <= '0;
         result_q <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else if (flush_i) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               if (start_i) begin
                  op_q   <= muldiv_op_e'(funct3_i);
                  sa_q   <= sa_in;
                  sb_q   <= sb_in;
                  dz_q   <= (b_i == '0);
                  acc_q  <= {{XLEN{1'b0}}, cond_neg(a_i, sa_in)};
                  bmag_q <= cond_neg(b_i, sb_in);
                  cnt_q  <= CW'(XLEN - 1);
`ifdef MULDIV_FAST_PATH_EN
                  if (fast_in) begin
                     state_q  <= StDone;
                     valid_q  <= 1'b1;
                     result_q <= fast_result;
                  end else begin
                     state_q <= StCalc;
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= StCalc;
                  busy_q  <= 1'b1;
`endif
               end
            end
            StCalc: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               result_q <= fix_result;
               valid_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign valid_o  = valid_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

   logic        clk_i    = 1'b0;
   logic        rst_ni   = 1'b0;
   logic        start_i  = 1'b0;
   logic        flush_i  = 1'b0;
   logic [2:0]  funct3_i = 3'b000;
   logic [31:0] a_i      = '0;
   logic [31:0] b_i      = '0;
   logic        busy_o, valid_o;
   logic [31:0] result_o;

   int checks = 0;
   int errors = 0;

`ifdef MULDIV_FAST_PATH_EN
   localparam int SpecLat  = 1;
   localparam int SpecBusy = 0;
`else
   localparam int SpecLat  = 34;
   localparam int SpecBusy = 33;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .funct3_i (funct3_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (busy_o),
      .valid_o  (valid_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op; optionally pulse start (ignored op) or flush in cycle T+poke_at.
   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input int poke_at, input logic poke_flush,
                      output logic [31:0] r, output int n, output int nb, output logic v);
      @(negedge clk_i);
      funct3_i = f; a_i = a; b_i = b; start_i = 1'b1;
      n = 0; nb = 0; v = 1'b0;
      while (!v && n < 60) begin
         @(posedge clk_i); #1;
         n++;
         start_i = 1'b0;
         flush_i = 1'b0;
         if (n == poke_at) begin
            if (poke_flush) begin
               flush_i = 1'b1;
            end else begin
               start_i = 1'b1; funct3_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
            end
         end
         nb += int'(busy_o);
         v = valid_o;
      end
      start_i = 1'b0;
      flush_i = 1'b0;
      r = result_o;
   endtask

   logic [31:0] res, prev;
   int          lat, nbusy, nvalid;
   logic        got_v;

   initial begin
      #12;
      check("rst_busy",   {31'b0, busy_o},  32'h0);
      check("rst_valid",  {31'b0, valid_o}, 32'h0);
      check("rst_result", result_o,         32'h0);
      @(negedge clk_i); rst_ni = 1'b1;

      run(3'b000, 32'd7, 32'hFFFFFFFD, 0, 1'b0, res, lat, nbusy, got_v);
      check("mul_res",  res,          32'hFFFFFFEB);
      check("mul_lat",  32'(lat),     32'd34);
      check("mul_busy", 32'(nbusy),   32'd33);

      run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat, nbusy, got_v);
      check("mulhu", res, 32'hFFFFFFFE);
      run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat, nbusy, got_v);
      check("mulh", res, 32'h00000000);
      run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat, nbusy, got_v);
      check("mulhsu", res, 32'hFFFFFFFF);
      run(3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 0, 1'b0, res, lat, nbusy, got_v);
      check("mul_negneg", res, 32'd30);

      run(3'b100, 32'hFFFFFFF9, 32'd2, 0, 1'b0, res, lat, nbusy, got_v);
      check("div", res, 32'hFFFFFFFD);
      run(3'b110, 32'hFFFFFFF9, 32'd2, 0, 1'b0, res, lat, nbusy, got_v);
      check("rem", res, 32'hFFFFFFFF);
      run(3'b101, 32'hFFFFFFF9, 32'd2, 0, 1'b0, res, lat, nbusy, got_v);
      check("divu", res, 32'h7FFFFFFC);
      run(3'b111, 32'd100, 32'd7, 0, 1'b0, res, lat, nbusy, got_v);
      check("remu", res, 32'd2);

      run(3'b101, 32'd5, 32'd0, 0, 1'b0, res, lat, nbusy, got_v);
      check("divu_z",      res,        32'hFFFFFFFF);
      check("divu_z_lat",  32'(lat),   32'(SpecLat));
      check("divu_z_busy", 32'(nbusy), 32'(SpecBusy));
      run(3'b111, 32'd5, 32'd0, 0, 1'b0, res, lat, nbusy, got_v);
      check("remu_z", res, 32'd5);
      run(3'b100, 32'hFFFFFFF9, 32'd0, 0, 1'b0, res, lat, nbusy, got_v);
      check("div_z", res, 32'hFFFFFFFF);
      run(3'b110, 32'hFFFFFFF9, 32'd0, 0, 1'b0, res, lat, nbusy, got_v);
      check("rem_z", res, 32'hFFFFFFF9);

      run(3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, res, lat, nbusy, got_v);
      check("div_ovf",     res,      32'h80000000);
      check("div_ovf_lat", 32'(lat), 32'(SpecLat));
      run(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, res, lat, nbusy, got_v);
      check("rem_ovf", res, 32'h00000000);

      // Start pulsed at T+5 while busy must not disturb the running op.
      run(3'b000, 32'd3, 32'd4, 5, 1'b0, res, lat, nbusy, got_v);
      check("ign_start_res", res,      32'd12);
      check("ign_start_lat", 32'(lat), 32'd34);

      // Back-to-back: this run begins in the DONE cycle of the previous one.
      run(3'b011, 32'h00010000, 32'h00010000, 0, 1'b0, res, lat, nbusy, got_v);
      check("b2b_res", res,      32'd1);
      check("b2b_lat", 32'(lat), 32'd34);
      prev = res;

      run(3'b000, 32'd9, 32'd9, 10, 1'b1, res, lat, nbusy, got_v);
      check("flush_novalid", {31'b0, got_v},  32'h0);
      check("flush_busy",    {31'b0, busy_o}, 32'h0);
      check("flush_result",  result_o,        prev);
      check("flush_busycnt", 32'(nbusy),      32'd10);

      // Flush and start together in IDLE: the start is dropped.
      @(negedge clk_i);
      funct3_i = 3'b000; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; flush_i = 1'b0;
      check("fs_busy", {31'b0, busy_o}, 32'h0);
      nvalid = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         nvalid += int'(valid_o);
      end
      check("fs_novalid", 32'(nvalid), 32'd0);

      // Asynchronous reset mid-operation takes effect before the next edge.
      @(negedge clk_i);
      funct3_i = 3'b000; a_i = 32'd6; b_i = 32'd7; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      check("arst_busy",   {31'b0, busy_o}, 32'h0);
      check("arst_result", result_o,        32'h0);
      @(negedge clk_i); rst_ni = 1'b1;

      run(3'b000, 32'd6, 32'd7, 0, 1'b0, res, lat, nbusy, got_v);
      check("post_rst_mul", res, 32'd42);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
